// File: rtl/rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl
//   Power-on / soft reset sequencer. Once the PLL has been locked for
//   STRETCH_CYCLES consecutive cycles it releases the DDR2 interface reset.
//   After DDR2 calibration completes it releases the Wishbone fabric reset,
//   and CPU_DELAY cycles later it releases the CPU reset. If calibration does
//   not complete within CALIB_TIMEOUT cycles it parks in FAULT. Losing lock or
//   an accepted software request re-runs the sequence.
//
// Ports
//   wb_clk            in   system clock, rising edge
//   wb_rst            in   synchronous active-high reset
//   locked_mcm        in   PLL lock (async, synchronised here)
//   ddr2_calib_done_i in   DDR2 calibration done (async, synchronised here)
//   sw_rst_req_i      in   one-cycle software reset request
//   sw_rst_ack_o      out  one-cycle pulse, request accepted
//   ddr2_if_rst_o     out  DDR2 interface reset, active-high
//   wb_rst_o          out  Wishbone fabric reset, active-high
//   cpu_rst_o         out  CPU reset, active-high
//   fault_o           out  sticky calibration-timeout flag
//   state_o           out  current state encoding (debug)
// ----------------------------------------------------------------------------
module rst_seq_ctrl #(
    parameter int STRETCH_CYCLES = 16,
    parameter int CALIB_TIMEOUT  = 65535,
    parameter int CPU_DELAY      = 8
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       locked_mcm,
    input  logic       ddr2_calib_done_i,
    input  logic       sw_rst_req_i,
    output logic       sw_rst_ack_o,
    output logic       ddr2_if_rst_o,
    output logic       wb_rst_o,
    output logic       cpu_rst_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    localparam int MAX_AB  = (STRETCH_CYCLES > CALIB_TIMEOUT) ? STRETCH_CYCLES : CALIB_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > CPU_DELAY) ? MAX_AB : CPU_DELAY;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    // Terminal counts; the counter is cleared on every state change, so it
    // never reaches past the largest of these and cannot wrap.
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST   = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CPU_LAST     = CNT_W'(CPU_DELAY - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK   = 3'd0,
        STRETCH     = 3'd1,
        WAIT_CALIB  = 3'd2,
        RELEASE_WB  = 3'd3,
        RELEASE_CPU = 3'd4,
        RUN         = 3'd5,
        FAULT       = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic               ack_q, ack_d;
    logic               ddr_rst_q, ddr_rst_d;
    logic               wb_rst_q, wb_rst_d;
    logic               cpu_rst_q, cpu_rst_d;

    // Two-flop synchronisers for the asynchronous status inputs
    logic               lock_meta_q, lock_s_q;
    logic               calib_meta_q, calib_s_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        ack_d   = 1'b0;

        // Lock loss overrides everything (including a software request),
        // except in FAULT which only a software request or wb_rst leaves.
        if (state_q != FAULT && !lock_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end
                STRETCH: begin
                    if (cnt_q == STRETCH_LAST) begin
                        state_d = WAIT_CALIB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_CALIB: begin
                    if (calib_s_q) begin
                        state_d = RELEASE_WB;
                        cnt_d   = '0;
                    end else if (cnt_q == CALIB_LAST) begin
                        state_d = FAULT;
                        cnt_d   = '0;
                        fault_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE_WB: begin
                    if (cnt_q == CPU_LAST) begin
                        state_d = RELEASE_CPU;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE_CPU: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (sw_rst_req_i) begin
                        state_d = STRETCH;
                        cnt_d   = '0;
                        ack_d   = 1'b1;
                    end
                end
                FAULT: begin
                    if (sw_rst_req_i && lock_s_q) begin
                        state_d = STRETCH;
                        cnt_d   = '0;
                        fault_d = 1'b0;
                        ack_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end

        // Reset outputs are decoded from the next state so they change on
        // the same edge as the state they belong to.
        ddr_rst_d = 1'b1;
        wb_rst_d  = 1'b1;
        cpu_rst_d = 1'b1;
        unique case (state_d)
            WAIT_CALIB: begin
                ddr_rst_d = 1'b0;
            end
            RELEASE_WB: begin
                ddr_rst_d = 1'b0;
                wb_rst_d  = 1'b0;
            end
            RELEASE_CPU, RUN: begin
                ddr_rst_d = 1'b0;
                wb_rst_d  = 1'b0;
                cpu_rst_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            fault_q      <= 1'b0;
            ack_q        <= 1'b0;
            ddr_rst_q    <= 1'b1;
            wb_rst_q     <= 1'b1;
            cpu_rst_q    <= 1'b1;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            calib_meta_q <= 1'b0;
            calib_s_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
            ack_q        <= ack_d;
            ddr_rst_q    <= ddr_rst_d;
            wb_rst_q     <= wb_rst_d;
            cpu_rst_q    <= cpu_rst_d;
            lock_meta_q  <= locked_mcm;
            lock_s_q     <= lock_meta_q;
            calib_meta_q <= ddr2_calib_done_i;
            calib_s_q    <= calib_meta_q;
        end
    end

    assign sw_rst_ack_o  = ack_q;
    assign ddr2_if_rst_o = ddr_rst_q;
    assign wb_rst_o      = wb_rst_q;
    assign cpu_rst_o     = cpu_rst_q;
    assign fault_o       = fault_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//   Directed scenarios plus a randomized run, checked against a timeline
//   model: the expected phase is derived from how long lock has been held
//   since the sequence restarted and when calibration was first seen.
// ----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

    localparam int SC = 16;
    localparam int CT = 100;
    localparam int CD = 8;

    logic       wb_clk = 1'b0;
    logic       wb_rst;
    logic       locked_mcm;
    logic       ddr2_calib_done_i;
    logic       sw_rst_req_i;
    logic       sw_rst_ack_o;
    logic       ddr2_if_rst_o;
    logic       wb_rst_o;
    logic       cpu_rst_o;
    logic       fault_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    rst_seq_ctrl #(
        .STRETCH_CYCLES(SC),
        .CALIB_TIMEOUT (CT),
        .CPU_DELAY     (CD)
    ) dut (
        .wb_clk           (wb_clk),
        .wb_rst           (wb_rst),
        .locked_mcm       (locked_mcm),
        .ddr2_calib_done_i(ddr2_calib_done_i),
        .sw_rst_req_i     (sw_rst_req_i),
        .sw_rst_ack_o     (sw_rst_ack_o),
        .ddr2_if_rst_o    (ddr2_if_rst_o),
        .wb_rst_o         (wb_rst_o),
        .cpu_rst_o        (cpu_rst_o),
        .fault_o          (fault_o),
        .state_o          (state_o)
    );

    always #5 wb_clk = ~wb_clk;

    // ---------------- timeline reference model ----------------
    // run_len: edges since the sequence (re)entered STRETCH, -1 = waiting for lock
    // rel    : run_len value at which the Wishbone release took effect, -1 = not yet
    int run_len = -1;
    int rel     = -1;
    bit faulted = 0;
    bit m_ack   = 0;
    bit lp1 = 0, lp2 = 0, cp1 = 0, cp2 = 0;

    function automatic int exp_state();
        int d;
        if (faulted)      return 6;
        if (run_len < 0)  return 0;
        if (run_len < SC) return 1;
        if (rel < 0)      return 2;
        d = run_len - rel;
        if (d < CD)       return 3;
        if (d == CD)      return 4;
        return 5;
    endfunction

    // {state, ddr_rst, wb_rst, cpu_rst, fault, ack}
    function automatic logic [7:0] model_vec();
        int s;
        s = exp_state();
        return {3'(s), !(s >= 2 && s <= 5), !(s >= 3 && s <= 5), !(s == 4 || s == 5),
                faulted, m_ack};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {state_o, ddr2_if_rst_o, wb_rst_o, cpu_rst_o, fault_o, sw_rst_ack_o};
    endfunction

    task automatic tick();
        bit ls, cs;
        int es;
        ls = lp2;
        cs = cp2;
        es = exp_state();
        @(posedge wb_clk);
        if (wb_rst) begin
            run_len = -1; rel = -1; faulted = 0; m_ack = 0;
            lp1 = 0; lp2 = 0; cp1 = 0; cp2 = 0;
        end else begin
            m_ack = 0;
            if (es == 6) begin
                if (sw_rst_req_i && ls) begin
                    faulted = 0; run_len = 0; rel = -1; m_ack = 1;
                end
            end else if (!ls) begin
                run_len = -1; rel = -1;
            end else if (es == 0) begin
                run_len = 0;
            end else if (es == 5 && sw_rst_req_i) begin
                run_len = 0; rel = -1; m_ack = 1;
            end else begin
                if (es == 2) begin
                    if (cs) rel = run_len + 1;
                    else if (run_len - SC == CT - 1) faulted = 1;
                end
                run_len++;
            end
            lp2 = lp1; lp1 = locked_mcm;
            cp2 = cp1; cp1 = ddr2_calib_done_i;
        end
        #1;
    endtask

    task automatic do_reset();
        wb_rst = 1'b1;
        locked_mcm = 1'b0;
        ddr2_calib_done_i = 1'b0;
        sw_rst_req_i = 1'b0;
        repeat (5) tick();
        wb_rst = 1'b0;
    endtask

    // Drive lock and calib high and wait for RUN; an expired bound is a failure.
    task automatic bring_up();
        int n;
        locked_mcm = 1'b1;
        ddr2_calib_done_i = 1'b1;
        n = 0;
        while (state_o != 3'd5 && n < 200) begin tick(); n++; end
        n_checks++;
        if (state_o !== 3'd5) $display("FAIL bring_up_timeout state=%0d want 5", state_o);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec() !== 8'b000_1_1_1_0_0)
            $display("FAIL reset_state got %b want %b", dut_vec(), 8'b000_1_1_1_0_0);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (dut_vec() !== model_vec() || state_o !== 3'd0)
            $display("FAIL idle_no_lock got %b want %b", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_bringup();
        int n;
        do_reset();
        locked_mcm = 1'b1;
        n = 0;
        while (ddr2_if_rst_o && n < 100) begin tick(); n++; end
        n_checks++;
        if (n != SC + 3) $display("FAIL ddr_release_latency got %0d want %0d", n, SC + 3);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== model_vec() || state_o !== 3'd2)
            $display("FAIL wait_calib_outputs got %b want %b", dut_vec(), model_vec());
        else n_pass++;
        repeat (5) tick();
        ddr2_calib_done_i = 1'b1;
        n = 0;
        while (wb_rst_o && n < 50) begin tick(); n++; end
        n_checks++;
        if (n != 3) $display("FAIL wb_release_latency got %0d want 3", n);
        else n_pass++;
        n = 0;
        while (cpu_rst_o && n < 50) begin tick(); n++; end
        n_checks++;
        if (n != CD) $display("FAIL cpu_release_delay got %0d want %0d", n, CD);
        else n_pass++;
        tick();
        n_checks++;
        if (dut_vec() !== 8'b101_0_0_0_0_0)
            $display("FAIL run_outputs got %b want %b", dut_vec(), 8'b101_0_0_0_0_0);
        else n_pass++;
    endtask

    task automatic test_lock_glitch();
        int n;
        bit saw_wait_lock;
        do_reset();
        locked_mcm = 1'b1;
        repeat (13) tick();          // STRETCH entered on edge 3, counter now 10
        n_checks++;
        if (state_o !== 3'd1 || dut_vec() !== model_vec())
            $display("FAIL mid_stretch got %b want %b", dut_vec(), model_vec());
        else n_pass++;
        locked_mcm = 1'b0;
        tick();
        locked_mcm = 1'b1;
        n = 0;
        saw_wait_lock = 0;
        while (ddr2_if_rst_o && n < 100) begin
            tick(); n++;
            if (state_o == 3'd0) saw_wait_lock = 1;
        end
        n_checks++;
        if (!saw_wait_lock) $display("FAIL glitch_wait_lock got 0 want 1");
        else n_pass++;
        n_checks++;
        if (n != SC + 3) $display("FAIL glitch_restart_latency got %0d want %0d", n, SC + 3);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        locked_mcm = 1'b1;
        n = 0;
        while (state_o != 3'd6 && n < 300) begin tick(); n++; end
        n_checks++;
        if (n != SC + 3 + CT) $display("FAIL timeout_latency got %0d want %0d", n, SC + 3 + CT);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== 8'b110_1_1_1_1_0)
            $display("FAIL fault_outputs got %b want %b", dut_vec(), 8'b110_1_1_1_1_0);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (fault_o !== 1'b1 || state_o !== 3'd6)
            $display("FAIL fault_sticky got %b want %b", dut_vec(), model_vec());
        else n_pass++;
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        n_checks++;
        if (dut_vec() !== 8'b001_1_1_1_0_1)
            $display("FAIL fault_sw_clear got %b want %b", dut_vec(), 8'b001_1_1_1_0_1);
        else n_pass++;
        tick();
        n_checks++;
        if (sw_rst_ack_o !== 1'b0 || dut_vec() !== model_vec())
            $display("FAIL ack_one_cycle got %b want %b", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_sw_run();
        int n;
        do_reset();
        bring_up();
        ddr2_calib_done_i = 1'b0;
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        n_checks++;
        if (dut_vec() !== 8'b001_1_1_1_0_1)
            $display("FAIL run_sw_req got %b want %b", dut_vec(), 8'b001_1_1_1_0_1);
        else n_pass++;
        n = 0;
        while (state_o != 3'd2 && n < 100) begin tick(); n++; end
        n_checks++;
        if (n != SC) $display("FAIL sw_restretch_len got %0d want %0d", n, SC);
        else n_pass++;
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        n_checks++;
        if (dut_vec() !== 8'b010_0_1_1_0_0 || dut_vec() !== model_vec())
            $display("FAIL req_ignored_wait_calib got %b want %b", dut_vec(), 8'b010_0_1_1_0_0);
        else n_pass++;
        bring_up();
    endtask

    task automatic test_lock_loss_run();
        do_reset();
        bring_up();
        locked_mcm = 1'b0;
        tick(); tick();
        n_checks++;
        if (dut_vec() !== 8'b101_0_0_0_0_0)
            $display("FAIL lock_loss_sync_delay got %b want %b", dut_vec(), 8'b101_0_0_0_0_0);
        else n_pass++;
        tick();
        n_checks++;
        if (dut_vec() !== 8'b000_1_1_1_0_0)
            $display("FAIL lock_loss_reassert got %b want %b", dut_vec(), 8'b000_1_1_1_0_0);
        else n_pass++;
    endtask

    task automatic test_lock_and_req();
        do_reset();
        bring_up();
        locked_mcm = 1'b0;
        tick(); tick();
        sw_rst_req_i = 1'b1;       // arrives with the synchronised lock loss
        tick();
        sw_rst_req_i = 1'b0;
        n_checks++;
        if (dut_vec() !== 8'b000_1_1_1_0_0)
            $display("FAIL lock_beats_req got %b want %b", dut_vec(), 8'b000_1_1_1_0_0);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            locked_mcm = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 59) == 0) ddr2_calib_done_i = ~ddr2_calib_done_i;
            sw_rst_req_i = ($urandom_range(0, 19) == 0);
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle_%0d got %b want %b", i, dut_vec(), model_vec());
            end else n_pass++;
            n_checks++;
            if ((!cpu_rst_o && wb_rst_o) || (!wb_rst_o && ddr2_if_rst_o)) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL reset_order_%0d got ddr=%b wb=%b cpu=%b want ordered",
                             i, ddr2_if_rst_o, wb_rst_o, cpu_rst_o);
            end else n_pass++;
        end
        sw_rst_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_glitch();
        test_timeout();
        test_sw_run();
        test_lock_loss_run();
        test_lock_and_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
